// File: rtl/fitness_session_tracker.sv
// -----------------------------------------------------------------------------
// fitness_session_tracker
//
// Workout-session engine. Accepts heart-rate / step samples over a valid/ready
// handshake while a session is ACTIVE, and accumulates steps, distance and
// elapsed seconds (all saturating). It also keeps a WIN-deep moving-average
// heart rate, a running maximum heart rate, and heart-rate / intensity classes.
//
// Optional feature macro: FST_HR_ALARM_EN
//   defined   -> consecutive-emergency-sample alarm counter is built.
//   undefined -> alarm output is tied low.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   tick_1hz                  one-cycle seconds strobe
//   cmd_start/pause/stop      single-cycle session commands (stop > pause > start)
//   s_valid / s_ready         sample handshake; s_ready = (state == ACTIVE)
//   hr_in, steps_in, stride_in  sample payload (bpm, steps, stride in cm)
//   state                     IDLE=00 ACTIVE=01 PAUSED=10 DONE=11
//   total_steps, total_distance, time_elapsed   saturating accumulators
//   hr_avg, hr_max            moving-average and maximum heart rate
//   hr_class                  class of last accepted sample (00/01/10)
//   intensity                 class of hr_avg (00 warm-up, 01 fat-burn, 10 cardio)
//   upd                       one-cycle pulse after each accepted sample
//   alarm                     emergency alarm (see macro above)
// -----------------------------------------------------------------------------
module fitness_session_tracker #(
  parameter int HR_W     = 8,
  parameter int WIN      = 8,
  parameter int STEP_W   = 16,
  parameter int DIST_W   = 32,
  parameter int TIME_W   = 16,
  parameter int SAFE_MAX = 150,
  parameter int WARN_MAX = 180,
  parameter int WARM_MAX = 120,
  parameter int FAT_MAX  = 160,
  parameter int ALARM_N  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1hz,
  input  logic              cmd_start,
  input  logic              cmd_pause,
  input  logic              cmd_stop,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [HR_W-1:0]   hr_in,
  input  logic [1:0]        steps_in,
  input  logic [7:0]        stride_in,
  output logic [1:0]        state,
  output logic [STEP_W-1:0] total_steps,
  output logic [DIST_W-1:0] total_distance,
  output logic [TIME_W-1:0] time_elapsed,
  output logic [HR_W-1:0]   hr_avg,
  output logic [HR_W-1:0]   hr_max,
  output logic [1:0]        hr_class,
  output logic [1:0]        intensity,
  output logic              upd,
  output logic              alarm
);

  localparam int LOG_W = $clog2(WIN);
  localparam int SUM_W = HR_W + LOG_W;

  localparam logic [HR_W-1:0] SAFE_MAX_V = HR_W'(SAFE_MAX);
  localparam logic [HR_W-1:0] WARN_MAX_V = HR_W'(WARN_MAX);
  localparam logic [HR_W-1:0] WARM_MAX_V = HR_W'(WARM_MAX);
  localparam logic [HR_W-1:0] FAT_MAX_V  = HR_W'(FAT_MAX);

  // Elaboration-time parameter sanity checks.
  if (WIN < 2 || WIN > 64 || (WIN & (WIN - 1)) != 0) begin : g_bad_win
    $error("WIN must be a power of two in 2..64");
  end
  if (ALARM_N < 1) begin : g_bad_alarm_n
    $error("ALARM_N must be at least 1");
  end
  if (DIST_W < 10) begin : g_bad_dist_w
    $error("DIST_W must hold a 10-bit per-sample distance");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    PAUSED = 2'b10,
    DONE   = 2'b11
  } state_t;

  state_t state_q, state_d;
  logic   clear_start;
  logic   accept;

  // ---------------------------------------------------------------------------
  // Saturation and classification helpers
  // ---------------------------------------------------------------------------
  function automatic logic [STEP_W-1:0] sat_add_steps(input logic [STEP_W-1:0] a,
                                                      input logic [1:0]        b);
    logic [STEP_W:0] s;
    s = {1'b0, a} + {{(STEP_W-1){1'b0}}, b};
    return s[STEP_W] ? {STEP_W{1'b1}} : s[STEP_W-1:0];
  endfunction

  function automatic logic [DIST_W-1:0] sat_add_dist(input logic [DIST_W-1:0] a,
                                                     input logic [9:0]        b);
    logic [DIST_W:0] s;
    s = {1'b0, a} + {{(DIST_W-9){1'b0}}, b};
    return s[DIST_W] ? {DIST_W{1'b1}} : s[DIST_W-1:0];
  endfunction

  function automatic logic [TIME_W-1:0] sat_inc_time(input logic [TIME_W-1:0] a);
    logic [TIME_W:0] s;
    s = {1'b0, a} + (TIME_W+1)'(1);
    return s[TIME_W] ? {TIME_W{1'b1}} : s[TIME_W-1:0];
  endfunction

  function automatic logic [1:0] classify_hr(input logic [HR_W-1:0] hr);
    if (hr <= SAFE_MAX_V)      return 2'b00;
    else if (hr <= WARN_MAX_V) return 2'b01;
    else                       return 2'b10;
  endfunction

  function automatic logic [1:0] classify_avg(input logic [HR_W-1:0] avg);
    if (avg < WARM_MAX_V)      return 2'b00;
    else if (avg <= FAT_MAX_V) return 2'b01;
    else                       return 2'b10;
  endfunction

  // ---------------------------------------------------------------------------
  // Session state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // clear_start marks a start that opens a fresh session (from IDLE or DONE).
  // In PAUSED a coincident pause outranks start, so the session stays paused.
  always_comb begin
    state_d     = state_q;
    clear_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          state_d     = ACTIVE;
          clear_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (cmd_stop)       state_d = DONE;
        else if (cmd_pause) state_d = PAUSED;
      end
      PAUSED: begin
        if (cmd_stop)       state_d = DONE;
        else if (cmd_pause) state_d = PAUSED;
        else if (cmd_start) state_d = ACTIVE;
      end
      DONE: begin
        if (cmd_start) begin
          state_d     = ACTIVE;
          clear_start = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state     = state_q;
  assign s_ready   = (state_q == ACTIVE);
  assign accept    = s_valid && s_ready;
  assign intensity = classify_avg(hr_avg);

  // ---------------------------------------------------------------------------
  // Moving-average window
  // ---------------------------------------------------------------------------
  logic [HR_W-1:0]  win_buf [WIN];
  logic [LOG_W-1:0] ptr_q;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             first_q;
  logic [9:0]       step_dist;

  assign step_dist = {8'b0, steps_in} * {2'b0, stride_in};

  // The first sample of a session fills the whole window so the average starts
  // at that sample instead of ramping up from zero.
  always_comb begin
    sum_d = sum_q;
    if (first_q) sum_d = {hr_in, {LOG_W{1'b0}}};
    else         sum_d = sum_q - SUM_W'(win_buf[ptr_q]) + SUM_W'(hr_in);
  end

  // ---------------------------------------------------------------------------
  // Accumulators (registered on the accepting edge)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_steps    <= '0;
      total_distance <= '0;
      time_elapsed   <= '0;
      hr_avg         <= '0;
      hr_max         <= '0;
      hr_class       <= 2'b00;
      upd            <= 1'b0;
      sum_q          <= '0;
      ptr_q          <= '0;
      first_q        <= 1'b1;
      for (int i = 0; i < WIN; i++) win_buf[i] <= '0;
    end else begin
      upd <= accept;
      if (clear_start) begin
        total_steps    <= '0;
        total_distance <= '0;
        time_elapsed   <= '0;
        hr_avg         <= '0;
        hr_max         <= '0;
        hr_class       <= 2'b00;
        sum_q          <= '0;
        ptr_q          <= '0;
        first_q        <= 1'b1;
      end else begin
        if (tick_1hz && state_q == ACTIVE)
          time_elapsed <= sat_inc_time(time_elapsed);
        if (accept) begin
          total_steps    <= sat_add_steps(total_steps, steps_in);
          total_distance <= sat_add_dist(total_distance, step_dist);
          if (hr_in > hr_max) hr_max <= hr_in;
          hr_class <= classify_hr(hr_in);
          sum_q    <= sum_d;
          hr_avg   <= sum_d[SUM_W-1:LOG_W];
          first_q  <= 1'b0;
          if (first_q) begin
            for (int i = 0; i < WIN; i++) win_buf[i] <= hr_in;
            ptr_q <= LOG_W'(1);
          end else begin
            win_buf[ptr_q] <= hr_in;
            ptr_q          <= ptr_q + LOG_W'(1);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Emergency alarm
  // ---------------------------------------------------------------------------
`ifdef FST_HR_ALARM_EN
  localparam int              CNT_W     = $clog2(ALARM_N + 1);
  localparam logic [CNT_W-1:0] ALARM_N_V = CNT_W'(ALARM_N);

  logic [CNT_W-1:0] emg_cnt_q, emg_cnt_d;
  logic             alarm_q;

  assign emg_cnt_d = (emg_cnt_q == ALARM_N_V) ? emg_cnt_q : emg_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      emg_cnt_q <= '0;
      alarm_q   <= 1'b0;
    end else if (clear_start) begin
      emg_cnt_q <= '0;
      alarm_q   <= 1'b0;
    end else if (accept) begin
      if (classify_hr(hr_in) == 2'b10) begin
        emg_cnt_q <= emg_cnt_d;
        if (emg_cnt_d == ALARM_N_V) alarm_q <= 1'b1;
      end else begin
        emg_cnt_q <= '0;
        alarm_q   <= 1'b0;
      end
    end
  end

  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: doc/fitness_session_tracker.md
# fitness_session_tracker

Parametrised workout-session engine for the fitness-monitor datapath, replacing the fixed-width step calculator. It accepts heart-rate and step samples over a valid/ready handshake and runs an IDLE/ACTIVE/PAUSED/DONE session state machine. It accumulates steps, distance and elapsed seconds with saturation, and keeps a WIN-deep moving-average heart rate plus a running maximum. It classifies instantaneous and average heart rate against parameter thresholds and sits between the sensor front end and the display/report logic.

## Interface
- HR_W, 8, heart-rate sample width
- WIN, 8, moving-average depth; power of two, 2..64
- STEP_W, 16, total-steps width
- DIST_W, 32, total-distance width
- TIME_W, 16, elapsed-seconds width
- SAFE_MAX, 150, upper bound of the safe heart-rate class
- WARN_MAX, 180, upper bound of the warning heart-rate class
- WARM_MAX, 120, heart-rate average below this is warm-up
- FAT_MAX, 160, heart-rate average at or below this is fat-burn
- ALARM_N, 4, consecutive emergency samples that raise the alarm
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- tick_1hz  in  1  one-cycle seconds strobe
- cmd_start, cmd_pause, cmd_stop  in  1 each  session commands; single-cycle pulses
- s_valid  in  1  sample valid
- s_ready  out  1  sample ready; equals (state==ACTIVE), combinational from state
- hr_in  in  HR_W  heart rate in bpm
- steps_in  in  2  steps this sample
- stride_in  in  8  stride length in cm
- state  out  2  IDLE=00, ACTIVE=01, PAUSED=10, DONE=11
- total_steps  out  STEP_W
- total_distance  out  DIST_W
- time_elapsed  out  TIME_W
- hr_avg  out  HR_W  moving average
- hr_max  out  HR_W
- hr_class  out  2  class of the last accepted sample: 00 safe, 01 warning, 10 emergency
- intensity  out  2  00 warm-up, 01 fat-burn, 10 cardio; combinational from hr_avg
- upd  out  1  one-cycle pulse after each accepted sample
- alarm  out  1  see Configuration

## Operation
- Reset: state IDLE. All counters, hr_avg, hr_max, hr_class, upd, alarm and the window buffer are 0.
- Command priority when pulses coincide: stop > pause > start.
- IDLE: start → ACTIVE with all accumulators cleared. Pause and stop are ignored.
- ACTIVE: pause → PAUSED; stop → DONE.
- PAUSED: start → ACTIVE, resuming with nothing cleared; stop → DONE.
- DONE: outputs hold; start → ACTIVE with all accumulators cleared.
- A sample is accepted when s_valid && s_ready. On acceptance:
  - total_steps += steps_in
  - total_distance += steps_in*stride_in (10-bit product, zero-extended)
  - hr_max = max(hr_max, hr_in)
  - hr_class = hr_in<=SAFE_MAX ? 00 : hr_in<=WARN_MAX ? 01 : 10
- Moving average: a circular buffer of WIN entries with a write pointer and a running sum of width HR_W+log2(WIN).
  - Normal sample: sum_new = sum − buf[ptr] + hr_in; buf[ptr] = hr_in; ptr wraps modulo WIN.
  - First sample after a clearing start: every entry is loaded with hr_in and sum = WIN*hr_in.
  - hr_avg = sum_new >> log2(WIN), truncated.
- Time: time_elapsed increments on each tick_1hz while in ACTIVE only.
- All accumulators saturate at all-ones; there is no wrap-around.
- intensity = hr_avg<WARM_MAX ? 00 : hr_avg<=FAT_MAX ? 01 : 10.
- Reset mid-session: returns immediately to the reset values. A partial window is discarded.

## Timing
- An accepted sample at edge N updates totals, hr_max, hr_class and hr_avg at edge N. upd is high in the cycle after edge N.
- intensity follows hr_avg in the same cycle.
- A command at edge N changes state at edge N. s_ready follows in the same cycle as the new state.
- Sample and pause in the same cycle: the sample is accepted, then the session pauses.
- Tick and pause in the same cycle: the tick is counted.
- Tick and start from PAUSED in the same cycle: the tick is not counted.
- Sample and stop in the same cycle: the sample is accepted.
- Back-to-back accepted samples every cycle are supported; throughput is 1 sample per cycle.

## Configuration
- FST_HR_ALARM_EN defined:
  - A counter of consecutive accepted emergency samples, saturating at ALARM_N.
  - alarm sets at the edge where the count reaches ALARM_N.
  - The first accepted non-emergency sample clears both the alarm and the counter.
  - Any clearing start also clears both.
  - Pause and DONE hold the alarm.
- FST_HR_ALARM_EN undefined: alarm is tied to 0 and the counter logic is absent.

## Test plan
- Reset, start, then 3 samples (hr 100, steps 2, stride 70) → total_steps 6, total_distance 420, hr_avg 100, hr_class 00, intensity 00, upd pulses 3.
- WIN=8, first sample 80, then 8 samples of 160 → hr_avg climbs by 10 per sample (90…160) and reaches 160 on the 8th 160-sample; hr_max 160; intensity reaches 01.
- Pause for 5 ticks, then resume for 3 ticks → time_elapsed +3 only. s_ready is 0 while paused and samples are not accepted.
- Preload total_steps 0xFFFE, then a sample with steps 3 → 0xFFFF. Stop, then start → all totals 0.
- Start, pause and stop in the same cycle → DONE. With FST_HR_ALARM_EN: 4 samples of hr 190 → alarm set on the 4th and cleared by the next hr 170.
- Assert rst mid-session with the window part-filled → state 00 and all outputs 0. The next start and sample 120 → hr_avg 120.
